n1_err_sweep: RTL
=================

// Module: n1_err_sweep
// PURPOSE
//  Self-checking sweep engine that drives every (a,b) operand pair into an approximate
//  multiplier (n1_4x4 or sibling) and consumes its product Y.
//  Accumulates error statistics against the exact a*b: error count, summed error distance, max error distance.
//  Sits beside the multiplier in the N1 characterisation top, replacing the simulation-only accuracy loop with synthesizable hardware.
// PARAMETERS
//  W       4   operand width; sweep covers 2^(2W) vectors
//  SETTLE  1   cycles a/b are held per vector before Y is sampled (>=1)
//  ED_W    16  width of summed-error-distance accumulator (saturating)
// PORTS
//  clk      in   1        rising-edge clock
//  rst      in   1        asynchronous, active-high reset
//  start    in   1        begin sweep; accepted only in IDLE or DONE
//  a        out  W        operand A to multiplier (registered)
//  b        out  W        operand B to multiplier (registered)
//  y        in   2W       multiplier product (combinational from a,b)
//  busy     out  1        high from the cycle after start is accepted until done
//  done     out  1        one-cycle pulse after the last vector is sampled
//  err_cnt  out  2W+1     number of vectors with y != a*b
//  sum_ed   out  ED_W     sum of |y - a*b|, saturates at all-ones
//  max_ed   out  2W       max |y - a*b| seen
//  sum_err  out  ED_W+1   signed sum of (y - a*b); see CONFIGURATION
// BEHAVIOUR
//  Reset: state IDLE; a, b, busy, done, err_cnt, sum_ed, max_ed, sum_err = 0. Applies at any time, including mid-sweep.
//  FSM states:
//   IDLE --start--> RUN
//   RUN --last sample--> DONE
//   DONE --start--> RUN
//   DONE with no start: remains DONE, results held.
//  Start acceptance: accepted on a clk edge in IDLE/DONE. Same edge clears all statistics, sets a=b=0 and settle_cnt=0. start while in RUN is ignored.
//  Ordering: a is the outer index, b the inner (b increments fastest). {a,b} sweeps 0 .. 2^(2W)-1.
//  Per vector: a/b held SETTLE cycles. y is sampled on the edge where settle_cnt==SETTLE-1; that edge advances {a,b} and clears settle_cnt.
//  Exact product: computed internally as a*b, width 2W. ed = |y - exact|, computed in 2W+1 bits signed.
//  Update on each sample edge:
//   - err_cnt += (ed != 0)
//   - sum_ed  = min(sum_ed + ed, 2^ED_W - 1)
//   - max_ed  = max(max_ed, ed)
//  Last vector (a=b=all-ones): after it is sampled, a,b wrap to 0 and state goes to DONE. done pulses on the following cycle; busy deasserts that same cycle.
//  Latency: 2^(2W)*SETTLE cycles from start edge to the last sample. done follows 1 cycle later.
//  Results: valid and stable from done until the next accepted start.
// CONFIGURATION
//  Macro N1_ERR_BIAS_EN:
//   - Defined: sum_err accumulates signed (y - exact) on every sample edge, wrapping in ED_W+1 bits. Used for mean-error bias.
//   - Undefined: the bias accumulator is not built and sum_err is tied to 0. The port list is unchanged.
// STRUCTURE
//  Shared header n1_defs.vh: state encodings S_IDLE/S_RUN/S_DONE, default W/SETTLE/ED_W.
//  Sub-module n1_err_accum: pure datapath taking y, exact, sample_en, clr and holding the statistic registers.
//  Top n1_err_sweep: owns the FSM, the operand counter and the settle counter.
//  The multiplier is NOT instantiated here; the characterisation top connects a/b/y to n1_4x4.
// TESTING
//  1. Exact model y=a*b, start -> done at cycle 257; err_cnt=0, sum_ed=0, max_ed=0, sum_err=0.
//  2. y=a*b with bit0 forced 0 -> err_cnt=64, sum_ed=64, max_ed=1, sum_err=-64 (N1_ERR_BIAS_EN).
//  3. y=0 -> err_cnt=225, sum_ed=14400, max_ed=225; same stimulus with ED_W=8 -> sum_ed=255 (saturated).
//  4. SETTLE=3, exact model -> each a/b pair held 3 cycles, done at cycle 769.
//  5. Assert start at vector 10 -> ignored, sweep continues. Assert rst at vector 100 -> all outputs 0, IDLE; a fresh start then completes normally.
//  6. Back-to-back: start in the DONE cycle -> statistics cleared, second sweep matches the first exactly.

Source files
------------

// File: rtl/n1_err_sweep_pkg.sv
// Shared definitions for the N1 error-sweep engine: FSM state encoding,
// default parameter values and a counter-width helper.
package n1_err_sweep_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Default geometry: 4-bit operands, one settle cycle, 16-bit error sum.
  localparam int N1_W_DEF      = 4;
  localparam int N1_SETTLE_DEF = 1;
  localparam int N1_ED_W_DEF   = 16;

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/n1_err_sweep_accum.sv
// Error-statistics datapath for the N1 sweep engine. Compares the sampled
// multiplier product against the exact product and accumulates error count,
// saturating summed error distance and maximum error distance.
// Optional signed bias accumulator is built only when N1_ERR_BIAS_EN is
// defined; otherwise sum_err is tied to zero.
module n1_err_sweep_accum #(
  parameter int W    = 4,
  parameter int ED_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              sample_en,
  input  logic [2*W-1:0]    y,
  input  logic [2*W-1:0]    exact,
  output logic [2*W:0]      err_cnt,
  output logic [ED_W-1:0]   sum_ed,
  output logic [2*W-1:0]    max_ed,
  output logic [ED_W:0]     sum_err
);

  localparam int PW = 2 * W;
  // Wide enough that sum_ed + ed never overflows before the saturation test.
  localparam int SW = ((ED_W > PW) ? ED_W : PW) + 1;
  localparam int EW = ED_W + 1;
  localparam logic [SW-1:0] ED_MAX = {{(SW-ED_W){1'b0}}, {ED_W{1'b1}}};

  logic signed [PW:0] diff;
  logic [PW-1:0]      ed;
  logic [SW-1:0]      sum_wide;

  logic [PW:0]        err_cnt_q, err_cnt_d;
  logic [ED_W-1:0]    sum_ed_q,  sum_ed_d;
  logic [PW-1:0]      max_ed_q,  max_ed_d;

  // Signed error y - exact and its magnitude.
  always_comb begin
    diff     = $signed({1'b0, y}) - $signed({1'b0, exact});
    ed       = diff[PW] ? PW'(-diff) : PW'(diff);
    sum_wide = SW'(sum_ed_q) + SW'(ed);
  end

  // Next-state for the statistics: clear on start, update on each sample.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    err_cnt_d = err_cnt_q;
    sum_ed_d  = sum_ed_q;
    max_ed_d  = max_ed_q;
    if (clr) begin
      err_cnt_d = '0;
      sum_ed_d  = '0;
      max_ed_d  = '0;
    end else if (sample_en) begin
      err_cnt_d = err_cnt_q + {{PW{1'b0}}, (ed != '0)};
      sum_ed_d  = (sum_wide > ED_MAX) ? {ED_W{1'b1}} : sum_wide[ED_W-1:0];
      max_ed_d  = (ed > max_ed_q) ? ed : max_ed_q;
    end
  end

  // Statistic registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
      sum_ed_q  <= '0;
      max_ed_q  <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      sum_ed_q  <= sum_ed_d;
      max_ed_q  <= max_ed_d;
    end
  end

  assign err_cnt = err_cnt_q;
  assign sum_ed  = sum_ed_q;
  assign max_ed  = max_ed_q;

`ifdef N1_ERR_BIAS_EN
  logic [ED_W:0] sum_err_q, sum_err_d;

  // Wrapping signed bias sum; the sized cast sign-extends diff.
  always_comb begin
    sum_err_d = sum_err_q;
    if (clr) begin
      sum_err_d = '0;
    end else if (sample_en) begin
      sum_err_d = sum_err_q + EW'(diff);
    end
  end

  // Bias register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_err_q <= '0;
    end else begin
      sum_err_q <= sum_err_d;
    end
  end

  assign sum_err = sum_err_q;
`else
  assign sum_err = '0;
`endif

endmodule

// File: rtl/n1_err_sweep.sv
// N1 error-sweep engine: walks every (a,b) operand pair through an external
// approximate multiplier, holding each pair SETTLE cycles, and accumulates
// error statistics of its product y against the exact a*b.
// Optional feature macro: N1_ERR_BIAS_EN (enables the signed bias sum on sum_err).
module n1_err_sweep
  import n1_err_sweep_pkg::*;
#(
  parameter int W      = N1_W_DEF,
  parameter int SETTLE = N1_SETTLE_DEF,
  parameter int ED_W   = N1_ED_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [W-1:0]      a,
  output logic [W-1:0]      b,
  input  logic [2*W-1:0]    y,
  output logic              busy,
  output logic              done,
  output logic [2*W:0]      err_cnt,
  output logic [ED_W-1:0]   sum_ed,
  output logic [2*W-1:0]    max_ed,
  output logic [ED_W:0]     sum_err
);

  localparam int IDX_W = 2 * W;
  localparam int SC_W  = cnt_width(SETTLE);

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;        // {a,b}: a is the outer index, b the inner
  logic [SC_W-1:0]   settle_cnt_q;
  logic              busy_q;
  logic              done_q;

  logic              start_acc;
  logic              sample_en;
  logic [IDX_W-1:0]  exact;

  // start is only honoured outside a sweep; y is sampled on the last settle cycle.
  assign start_acc = start && (state_q != S_RUN);
  assign sample_en = (state_q == S_RUN) && (settle_cnt_q == SC_W'(SETTLE - 1));

  assign a     = idx_q[IDX_W-1:W];
  assign b     = idx_q[W-1:0];
  assign exact = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign busy  = busy_q;
  assign done  = done_q;

  // Sweep FSM with operand counter, settle counter and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      settle_cnt_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q      <= S_RUN;
            idx_q        <= '0;
            settle_cnt_q <= '0;
            busy_q       <= 1'b1;
          end
        end
        S_RUN: begin
          if (sample_en) begin
            idx_q        <= idx_q + 1'b1;
            settle_cnt_q <= '0;
            if (&idx_q) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            settle_cnt_q <= settle_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  n1_err_sweep_accum #(
    .W    (W),
    .ED_W (ED_W)
  ) u_accum (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_acc),
    .sample_en (sample_en),
    .y         (y),
    .exact     (exact),
    .err_cnt   (err_cnt),
    .sum_ed    (sum_ed),
    .max_ed    (max_ed),
    .sum_err   (sum_err)
  );

endmodule
